vga_fb_write_arbiter: RTL and testbench

- Controls the single framebuffer write port (color, we, x address, y address) of the VGA display core.
- Shares that port between NREQ pixel-write requesters using valid/ready handshakes and round-robin arbitration.
- Contains a built-in full-screen clear sequencer that takes exclusive ownership of the port while it runs.
- Can optionally restrict framebuffer writes to blanking intervals.

---
 rtl/vga_fb_write_arbiter.sv | 176 +++++++++++++++++
 tb/tb_vga_fb_write_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_write_arbiter.sv
// Framebuffer write-port arbiter for the VGA display core.
// Round-robin shares one registered write port between NREQ valid/ready
// requesters. A built-in clear sequencer sweeps the whole screen and owns
// the port exclusively while it runs. Writes can optionally be held off
// until the display is in a blanking interval.
module vga_fb_write_arbiter #(
  parameter int NREQ       = 2,
  parameter int HD         = 1280,
  parameter int VD         = 1024,
  parameter int AW         = 11,
  parameter int BLANK_ONLY = 0,
  localparam int GW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 arstn,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [2*NREQ-1:0]    req_color_i,
  input  logic [AW*NREQ-1:0]   req_x_i,
  input  logic [AW*NREQ-1:0]   req_y_i,
  input  logic                 blank_i,
  input  logic                 clear_i,
  input  logic [1:0]           clear_color_i,
  output logic                 clear_busy_o,
  output logic                 fb_we_o,
  output logic [1:0]           fb_color_o,
  output logic [AW-1:0]        fb_addr_x_o,
  output logic [AW-1:0]        fb_addr_y_o,
  output logic [GW-1:0]        grant_id_o
);

  localparam logic [AW:0]   HD_L    = (AW+1)'(HD);
  localparam logic [AW:0]   VD_L    = (AW+1)'(VD);
  localparam logic [AW-1:0] HD_LAST = AW'(HD - 1);
  localparam logic [AW-1:0] VD_LAST = AW'(VD - 1);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cx_q, cx_d, cy_q, cy_d;
  logic [1:0]    clr_col_q, clr_col_d;
  logic [GW-1:0] ptr_q, ptr_d;
  logic [GW-1:0] gid_q, gid_d;
  logic          busy_q, busy_d;
  logic          we_q, we_d;
  logic [1:0]    col_q, col_d;
  logic [AW-1:0] ax_q, ax_d, ay_q, ay_d;

  logic          allow;
  logic          gnt_found;
  logic [GW-1:0] gnt_idx;
  int unsigned   idx;
  logic          grant;
  logic [AW-1:0] sel_x, sel_y;
  logic [1:0]    sel_col;
  logic          in_range;

  assign allow = (BLANK_ONLY == 0) ? 1'b1 : blank_i;

  // Round-robin search: first valid requester at or above the pointer, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr_q) + k) % NREQ;
      if (!gnt_found && req_valid_i[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = GW'(idx);
      end
    end
  end

  // Grant is suppressed during reset, while clearing, when a clear starts,
  // and outside blanking when writes are restricted.
  assign grant       = arstn && (state_q == ST_IDLE) && allow && !clear_i && gnt_found;
  assign req_ready_o = grant ? (NREQ'(1) << gnt_idx) : '0;

  assign sel_x    = req_x_i[gnt_idx*AW +: AW];
  assign sel_y    = req_y_i[gnt_idx*AW +: AW];
  assign sel_col  = req_color_i[gnt_idx*2 +: 2];
  assign in_range = ({1'b0, sel_x} < HD_L) && ({1'b0, sel_y} < VD_L);

  // Next-state logic for the arbiter, clear sweep and registered write port.
  always_comb begin
    state_d   = state_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    clr_col_d = clr_col_q;
    ptr_d     = ptr_q;
    gid_d     = gid_q;
    busy_d    = busy_q;
    we_d      = 1'b0;
    col_d     = col_q;
    ax_d      = ax_q;
    ay_d      = ay_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_i) begin
          state_d   = ST_CLEAR;
          cx_d      = '0;
          cy_d      = '0;
          clr_col_d = clear_color_i;
          busy_d    = 1'b1;
        end else if (grant) begin
          ptr_d = (gnt_idx == GW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
          gid_d = gnt_idx;
          // Out-of-range requests are consumed but never reach the framebuffer.
          if (in_range) begin
            we_d  = 1'b1;
            col_d = sel_col;
            ax_d  = sel_x;
            ay_d  = sel_y;
          end
        end
      end
      ST_CLEAR: begin
        if (allow) begin
          we_d  = 1'b1;
          ax_d  = cx_q;
          ay_d  = cy_q;
          col_d = clr_col_q;
          if (cx_q == HD_LAST) begin
            cx_d = '0;
            if (cy_q == VD_LAST) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end else begin
              cy_d = cy_q + 1'b1;
            end
          end else begin
            cx_d = cx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; async reset aborts any clear in progress.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q   <= ST_IDLE;
      cx_q      <= '0;
      cy_q      <= '0;
      clr_col_q <= '0;
      ptr_q     <= '0;
      gid_q     <= '0;
      busy_q    <= 1'b0;
      we_q      <= 1'b0;
      col_q     <= '0;
      ax_q      <= '0;
      ay_q      <= '0;
    end else begin
      state_q   <= state_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      clr_col_q <= clr_col_d;
      ptr_q     <= ptr_d;
      gid_q     <= gid_d;
      busy_q    <= busy_d;
      we_q      <= we_d;
      col_q     <= col_d;
      ax_q      <= ax_d;
      ay_q      <= ay_d;
    end
  end

  assign clear_busy_o = busy_q;
  assign fb_we_o      = we_q;
  assign fb_color_o   = col_q;
  assign fb_addr_x_o  = ax_q;
  assign fb_addr_y_o  = ay_q;
  assign grant_id_o   = gid_q;

endmodule

// File: tb/tb_vga_fb_write_arbiter.sv
// Directed bench for vga_fb_write_arbiter using three instances:
// u_a default geometry, u_c a 4x2 screen for clear sweeps, u_b blank-only.
module tb_vga_fb_write_arbiter;

  logic clk;
  logic arstn;
  int   checks;
  int   errors;

  // Instance A: defaults
  logic [1:0]  a_valid, a_ready, a_ccol, a_col;
  logic [3:0]  a_color;
  logic [21:0] a_x, a_y;
  logic        a_blank, a_clear, a_busy, a_we;
  logic [10:0] a_ax, a_ay;
  logic [0:0]  a_gid;

  // Instance C: HD=4, VD=2
  logic [1:0]  c_valid, c_ready, c_ccol, c_col;
  logic [3:0]  c_color;
  logic [21:0] c_x, c_y;
  logic        c_blank, c_clear, c_busy, c_we;
  logic [10:0] c_ax, c_ay;
  logic [0:0]  c_gid;

  // Instance B: BLANK_ONLY=1
  logic [1:0]  b_valid, b_ready, b_ccol, b_col;
  logic [3:0]  b_color;
  logic [21:0] b_x, b_y;
  logic        b_blank, b_clear, b_busy, b_we;
  logic [10:0] b_ax, b_ay;
  logic [0:0]  b_gid;

  vga_fb_write_arbiter u_a (
    .clk(clk), .arstn(arstn), .req_valid_i(a_valid), .req_ready_o(a_ready),
    .req_color_i(a_color), .req_x_i(a_x), .req_y_i(a_y), .blank_i(a_blank),
    .clear_i(a_clear), .clear_color_i(a_ccol), .clear_busy_o(a_busy),
    .fb_we_o(a_we), .fb_color_o(a_col), .fb_addr_x_o(a_ax), .fb_addr_y_o(a_ay),
    .grant_id_o(a_gid)
  );

  vga_fb_write_arbiter #(.HD(4), .VD(2)) u_c (
    .clk(clk), .arstn(arstn), .req_valid_i(c_valid), .req_ready_o(c_ready),
    .req_color_i(c_color), .req_x_i(c_x), .req_y_i(c_y), .blank_i(c_blank),
    .clear_i(c_clear), .clear_color_i(c_ccol), .clear_busy_o(c_busy),
    .fb_we_o(c_we), .fb_color_o(c_col), .fb_addr_x_o(c_ax), .fb_addr_y_o(c_ay),
    .grant_id_o(c_gid)
  );

  vga_fb_write_arbiter #(.BLANK_ONLY(1)) u_b (
    .clk(clk), .arstn(arstn), .req_valid_i(b_valid), .req_ready_o(b_ready),
    .req_color_i(b_color), .req_x_i(b_x), .req_y_i(b_y), .blank_i(b_blank),
    .clear_i(b_clear), .clear_color_i(b_ccol), .clear_busy_o(b_busy),
    .fb_we_o(b_we), .fb_color_o(b_col), .fb_addr_x_o(b_ax), .fb_addr_y_o(b_ay),
    .grant_id_o(b_gid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Reset with every input active
    arstn   = 1'b0;
    a_valid = 2'b11; c_valid = 2'b11; b_valid = 2'b11;
    a_clear = 1'b1;  c_clear = 1'b1;  b_clear = 1'b1;
    a_blank = 1'b1;  c_blank = 1'b1;  b_blank = 1'b1;
    a_ccol  = 2'b11; c_ccol  = 2'b11; b_ccol  = 2'b11;
    a_color = 4'b1001;   // req1 color 2, req0 color 1
    a_x     = {11'd9, 11'd5};
    a_y     = {11'd3, 11'd7};
    c_color = 4'hF; c_x = '1; c_y = '1;
    b_color = 4'hF; b_x = '1; b_y = '1;
    #12;
    chk("rst_a_ready", 32'(a_ready), 0);
    chk("rst_a_we",    32'(a_we),    0);
    chk("rst_a_busy",  32'(a_busy),  0);
    chk("rst_a_x",     32'(a_ax),    0);
    chk("rst_a_y",     32'(a_ay),    0);
    chk("rst_a_col",   32'(a_col),   0);
    chk("rst_a_gid",   32'(a_gid),   0);
    chk("rst_c_ready", 32'(c_ready), 0);
    chk("rst_c_busy",  32'(c_busy),  0);
    chk("rst_b_ready", 32'(b_ready), 0);
    #5;
    // Release reset between edges
    arstn   = 1'b1;
    a_clear = 1'b0; c_clear = 1'b0; b_clear = 1'b0;
    c_valid = 2'b00; b_valid = 2'b00;
    a_ccol  = 2'b00; c_ccol  = 2'b00; b_ccol  = 2'b00;
    #1;
    chk("first_ready", 32'(a_ready), 32'b01);

    // Round robin with both requesters valid for four cycles
    tick;
    chk("rr1_we",    32'(a_we),    1);
    chk("rr1_x",     32'(a_ax),    5);
    chk("rr1_y",     32'(a_ay),    7);
    chk("rr1_col",   32'(a_col),   1);
    chk("rr1_gid",   32'(a_gid),   0);
    chk("rr1_ready", 32'(a_ready), 32'b10);
    tick;
    chk("rr2_we",    32'(a_we),    1);
    chk("rr2_x",     32'(a_ax),    9);
    chk("rr2_y",     32'(a_ay),    3);
    chk("rr2_col",   32'(a_col),   2);
    chk("rr2_gid",   32'(a_gid),   1);
    chk("rr2_ready", 32'(a_ready), 32'b01);
    tick;
    chk("rr3_gid",   32'(a_gid),   0);
    chk("rr3_x",     32'(a_ax),    5);
    chk("rr3_ready", 32'(a_ready), 32'b10);
    tick;
    chk("rr4_gid",   32'(a_gid),   1);
    chk("rr4_x",     32'(a_ax),    9);
    a_valid = 2'b00;
    #1;
    chk("idle_ready", 32'(a_ready), 0);
    tick;
    chk("idle_we",    32'(a_we),    0);
    chk("idle_xhold", 32'(a_ax),    9);
    chk("idle_chold", 32'(a_col),   2);

    // Out-of-range request: consumed, no write, pointer advances
    a_x     = {11'd9, 11'd1280};
    a_y     = {11'd3, 11'd0};
    a_color = 4'b1011;
    a_valid = 2'b01;
    #1;
    chk("oor_ready", 32'(a_ready), 32'b01);
    tick;
    chk("oor_we",    32'(a_we),    0);
    chk("oor_xhold", 32'(a_ax),    9);
    chk("oor_gid",   32'(a_gid),   0);
    a_valid = 2'b11;
    #1;
    chk("oor_ptr_adv", 32'(a_ready), 32'b10);
    a_valid = 2'b00;

    // Blank-only: writes wait for blanking
    b_blank = 1'b0;
    b_color = 4'b1100;   // req1 color 3
    b_x     = {11'd100, 11'd0};
    b_y     = {11'd200, 11'd0};
    b_valid = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bo_noready", 32'(b_ready), 0);
      tick;
      chk("bo_nowe", 32'(b_we), 0);
    end
    b_blank = 1'b1;
    #1;
    chk("bo_ready", 32'(b_ready), 32'b10);
    tick;
    chk("bo_we",  32'(b_we),  1);
    chk("bo_x",   32'(b_ax),  100);
    chk("bo_y",   32'(b_ay),  200);
    chk("bo_col", 32'(b_col), 3);
    chk("bo_gid", 32'(b_gid), 1);
    b_valid = 2'b00;

    // Full clear on a 4x2 screen, requester 0 waiting throughout
    c_color = 4'b0001;   // req0 color 1
    c_x     = {11'd0, 11'd2};
    c_y     = {11'd0, 11'd1};
    c_valid = 2'b01;
    c_clear = 1'b1;
    c_ccol  = 2'd2;
    #1;
    chk("clr_prio_ready", 32'(c_ready), 0);
    tick;
    c_clear = 1'b0;
    c_ccol  = 2'd1;
    chk("clr_busy0",  32'(c_busy), 1);
    chk("clr_we0",    32'(c_we),   0);
    #1;
    chk("clr_ready0", 32'(c_ready), 0);
    for (int k = 0; k < 8; k++) begin
      if (k == 3) c_clear = 1'b1;
      tick;
      c_clear = 1'b0;
      chk("clr_we",   32'(c_we),   1);
      chk("clr_x",    32'(c_ax),   32'(k % 4));
      chk("clr_y",    32'(c_ay),   32'(k / 4));
      chk("clr_col",  32'(c_col),  2);
      chk("clr_busy", 32'(c_busy), (k < 7) ? 1 : 0);
      #1;
      chk("clr_ready", 32'(c_ready), (k < 7) ? 0 : 32'b01);
    end
    tick;
    chk("post_clr_we",  32'(c_we),  1);
    chk("post_clr_x",   32'(c_ax),  2);
    chk("post_clr_y",   32'(c_ay),  1);
    chk("post_clr_col", 32'(c_col), 1);
    chk("post_clr_gid", 32'(c_gid), 0);
    c_valid = 2'b00;
    tick;
    chk("post_clr_idle", 32'(c_we), 0);

    // Reset in the middle of a clear after three writes
    c_clear = 1'b1;
    c_ccol  = 2'd3;
    tick;
    c_clear = 1'b0;
    tick; tick; tick;
    chk("mid_we",   32'(c_we),   1);
    chk("mid_x",    32'(c_ax),   2);
    chk("mid_busy", 32'(c_busy), 1);
    #1;
    arstn = 1'b0;
    #1;
    chk("arst_we",   32'(c_we),   0);
    chk("arst_busy", 32'(c_busy), 0);
    #2;
    arstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("after_arst_we",   32'(c_we),   0);
      chk("after_arst_busy", 32'(c_busy), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
